btn_scan_ctrl: RTL and testbench
================================

Name: btn_scan_ctrl

Overview:
- Shares one debounce counter among NUM_BTN push-buttons using a round-robin scan scheduler.
- Produces a debounced level and a one-cycle press pulse per button.
- Sits between the board button pins and the stopwatch control logic (pause/reset/select). Replaces one counter per button.
- Only one button is qualified at a time; the others wait their scan turn.

Parameters:
- NUM_BTN, 4, number of buttons scanned (>=2).
- CNT_W, 16, width of the shared qualification counter.
- HOLD_MAX, 16'hFFFF, value the counter must reach for a change to be accepted (must fit CNT_W).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- btn_raw  input  NUM_BTN  asynchronous raw button pins, active-high.
- btn_level  output  NUM_BTN  debounced button state, registered.
- btn_pulse  output  NUM_BTN  one-cycle pulse on each debounced 0->1 transition, registered.
- busy  output  1  high while in QUALIFY.
- active_idx  output  IDX_W  current scan pointer; IDX_W = clog2(NUM_BTN).

Behaviour:
- Clocking and reset
  - One clock domain (clk). Reset is synchronous and active-high (rst).
  - On rst: btn_level=0, btn_pulse=0, busy=0, active_idx=0, counter=0, state=SCAN, synchronizer flops=0.
  - rst during QUALIFY aborts the qualification with no level change and no pulse.
- Synchronizer
  - Each btn_raw bit passes through two flops to give sync[i], a 2-cycle latency.
- Mismatch
  - mismatch(i) = sync[i] != btn_level[i].
- State SCAN
  - If mismatch(active_idx): go to QUALIFY, counter=0, active_idx held.
  - Otherwise active_idx <= active_idx+1, wrapping from NUM_BTN-1 to 0.
- State QUALIFY (busy=1)
  - If mismatch(active_idx) still holds:
    - If counter==HOLD_MAX: commit by toggling btn_level[active_idx], clear counter, go to SCAN, active_idx+1.
    - Otherwise counter++.
  - If the mismatch disappears (bounce): clear counter, go to SCAN, active_idx+1, no level change.
- Press latency
  - A commit occurs on the (HOLD_MAX+1)th QUALIFY cycle.
  - The new btn_level is visible on the following edge.
- btn_pulse
  - btn_pulse[i]=1 only in the cycle where btn_level[i] first reads 1 after a commit; 0 otherwise.
  - Release commits never pulse.
- Arbitration
  - Buttons pending at the same time are served in scan order starting from active_idx.
  - A button pending while another qualifies waits; it is inspected at most NUM_BTN-1 SCAN cycles after the current qualification ends.
- Counter
  - CNT_W bits, never wraps: it is cleared at HOLD_MAX on commit.
- Press held forever
  - After commit there is no mismatch, so there is exactly one pulse and no auto-repeat.

Optional Feature:
- Macro: BTN_RELEASE_DEBOUNCE_EN.
- Defined:
  - 1->0 transitions go through SCAN/QUALIFY exactly like presses.
  - A release is accepted only after HOLD_MAX+1 stable cycles.
- Undefined (default):
  - Any i with sync[i]==0 and btn_level[i]==1 clears btn_level[i] on the next edge.
  - This applies to all buttons in parallel and in any state.
  - SCAN/QUALIFY then only ever qualify 0->1 transitions.
  - If the qualifying button's sync drops, the bounce rule applies in the same cycle.

Decomposition:
- Package btn_ctrl_pkg holds:
  - the state enum {SCAN, QUALIFY};
  - the IDX_W calculation function;
  - the default HOLD_MAX constant;
  - the reduced simulation constant HOLD_SIM=15.
- Sub-module btn_sync: 2-flop synchronizer, 1 bit, with rst. Instantiate NUM_BTN copies with a generate loop.

Test Plan:
- NUM_BTN=4, HOLD_MAX=15. Hold btn_raw[2]=1 constantly -> btn_level[2] rises once and btn_pulse[2] is high exactly 1 cycle. Check against a cycle count from the raw edge (2 sync cycles + scan delay + 16 QUALIFY cycles + 1).
- Toggle btn_raw[1] 1/0 every 5 cycles for 100 cycles -> btn_level[1] stays 0, no pulse, busy toggles, and active_idx keeps advancing after each abort.
- Press btn_raw[0] and btn_raw[3] in the same cycle with active_idx=3 -> button 3 commits first and button 0 commits after a further 16+ cycles. Exactly one pulse each.
- Assert rst on the 10th QUALIFY cycle of button 1 -> the next cycle shows all outputs 0, active_idx=0, state SCAN. Release rst with the button still held -> a full new qualification completes before the commit.
- Release test without BTN_RELEASE_DEBOUNCE_EN: with btn_level[2]=1, drop btn_raw[2] -> btn_level[2]=0 exactly 3 cycles later (2 sync + 1), and there is no pulse.
- Release test with BTN_RELEASE_DEBOUNCE_EN defined: drop btn_raw[2] -> btn_level[2] clears only after 16 stable QUALIFY cycles. A 5-cycle glitch back to 1 during the release keeps btn_level[2]=1.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// Shared types and constants for the round-robin button debounce controller.
package btn_ctrl_pkg;

    typedef enum logic {
        SCAN    = 1'b0,
        QUALIFY = 1'b1
    } scan_state_t;

    // Full-rate hold count and the reduced count used for short simulations.
    localparam int unsigned HOLD_MAX_DEFAULT = 32'h0000_FFFF;
    localparam int unsigned HOLD_SIM         = 15;

    // Scan pointer width; a single button still needs one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for one asynchronous button pin.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Capture the raw pin, then re-register to let metastability settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// Round-robin debounce of NUM_BTN buttons sharing a single hold counter.
// Optional macro BTN_RELEASE_DEBOUNCE_EN: releases are qualified like presses;
// without it a release clears the level one cycle after the synchronized drop.
module btn_scan_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BTN  = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
    localparam int unsigned IDX_W   = idx_w(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               busy,
    output logic [IDX_W-1:0]   active_idx
);

    logic [NUM_BTN-1:0] sync;
    scan_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_d, idx_next;
    logic [NUM_BTN-1:0] level_d, pulse_d;
    logic               busy_d;
    logic               mismatch;

    // One synchronizer per button pin.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_sync
        btn_sync u_sync (
            .clk (clk),
            .rst (rst),
            .d   (btn_raw[g]),
            .q   (sync[g])
        );
    end

    // Scan pointer successor with wrap to button 0.
    always_comb begin
        idx_next = active_idx + IDX_W'(1);
        if (active_idx == IDX_W'(NUM_BTN - 1)) begin
            idx_next = '0;
        end
    end

    // Difference that the shared counter qualifies for the scanned button.
    always_comb begin
`ifdef BTN_RELEASE_DEBOUNCE_EN
        mismatch = sync[active_idx] ^ btn_level[active_idx];
`else
        mismatch = sync[active_idx] & ~btn_level[active_idx];
`endif
    end

    // Scan scheduler next-state, counter and level update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = active_idx;
`ifdef BTN_RELEASE_DEBOUNCE_EN
        level_d = btn_level;
`else
        // Releases bypass the scheduler and clear all buttons in parallel.
        level_d = btn_level & sync;
`endif
        case (state_q)
            SCAN: begin
                if (mismatch) begin
                    state_d = QUALIFY;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_next;
                end
            end
            QUALIFY: begin
                if (mismatch) begin
                    if (cnt_q == CNT_W'(HOLD_MAX)) begin
                        level_d[active_idx] = ~btn_level[active_idx];
                        cnt_d   = '0;
                        state_d = SCAN;
                        idx_d   = idx_next;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Bounce: give up this turn without touching the level.
                    cnt_d   = '0;
                    state_d = SCAN;
                    idx_d   = idx_next;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
        pulse_d = level_d & ~btn_level;
        busy_d  = (state_d == QUALIFY);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            active_idx <= '0;
            btn_level  <= '0;
            btn_pulse  <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            active_idx <= idx_d;
            btn_level  <= level_d;
            btn_pulse  <= pulse_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// Scoreboard bench for btn_scan_ctrl with a reduced hold count.
module tb_btn_scan_ctrl;
    import btn_ctrl_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned IW = idx_w(NB);

    typedef struct {
        int          cyc;
        logic [NB-1:0] level;
        logic [NB-1:0] pulse;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          busy;
    logic [IW-1:0] active_idx;

    int            cyc    = 0;
    int            n_vec  = 0;
    int            n_err  = 0;
    bit            mon_en = 1'b0;
    logic [NB-1:0] prev_level = '0;
    ev_t           exp_q[$];
    ev_t           mon_e;

    btn_scan_ctrl #(
        .NUM_BTN  (NB),
        .CNT_W    (16),
        .HOLD_MAX (HOLD_SIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .busy       (busy),
        .active_idx (active_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every level change or pulse is one DUT event checked against the queue.
    always @(negedge clk) begin
        if (mon_en && ((btn_level !== prev_level) || (btn_pulse !== '0))) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event cyc=%0d level=%b pulse=%b", cyc, btn_level, btn_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.cyc != cyc || mon_e.level !== btn_level || mon_e.pulse !== btn_pulse) begin
                    n_err++;
                    $display("FAIL event: got cyc=%0d level=%b pulse=%b, expected cyc=%0d level=%b pulse=%b",
                             cyc, btn_level, btn_pulse, mon_e.cyc, mon_e.level, mon_e.pulse);
                end
            end
        end
        prev_level = btn_level;
    end

    task automatic push(input int c, input logic [NB-1:0] l, input logic [NB-1:0] p);
        ev_t e;
        e.cyc   = c;
        e.level = l;
        e.pulse = p;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc=%0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Two-cycle reset; optionally expect the level clear it causes.
    task automatic do_reset(input bit expect_clear, output int r);
        rst = 1'b1;
        if (expect_clear) push(cyc + 1, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        r   = cyc;
    endtask

    initial begin
        int p, d, r, rises, aborts;
        logic pb;

        rst     = 1'b1;
        btn_raw = '0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        r      = cyc;
        mon_en = 1'b1;

        // Reset state
        check("rst_level", int'(btn_level), 0);
        check("rst_pulse", int'(btn_pulse), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_idx", int'(active_idx), 0);

        // Held press on button 2: pointer is at 3 when sync rises, so 3 scan cycles of wait
        @(negedge clk);
        p = cyc;
        btn_raw[2] = 1'b1;
        push(p + 22, 4'b0100, 4'b0100);
        wait_until(p + 5);
        check("t1_busy_pre", int'(busy), 0);
        check("t1_idx_pre", int'(active_idx), 2);
        wait_until(p + 6);
        check("t1_busy_q", int'(busy), 1);
        check("t1_idx_q", int'(active_idx), 2);
        wait_until(p + 22);
        check("t1_idx_commit", int'(active_idx), 3);
        check("t1_busy_commit", int'(busy), 0);

        // Release of button 2
        wait_until(p + 32);
        d = cyc;
        btn_raw[2] = 1'b0;
`ifdef BTN_RELEASE_DEBOUNCE_EN
        wait_until(d + 8);
        btn_raw[2] = 1'b1;
        wait_until(d + 13);
        btn_raw[2] = 1'b0;
        push(d + 35, 4'b0000, 4'b0000);
        wait_until(d + 20);
        check("rel_glitch_level", int'(btn_level[2]), 1);
        wait_until(d + 40);
`else
        push(d + 3, 4'b0000, 4'b0000);
        wait_until(d + 2);
        check("rel_level_pre", int'(btn_level[2]), 1);
        wait_until(d + 10);
`endif

        // Bouncing button 1: 5 high / 5 low, never long enough to commit
        do_reset(1'b0, r);
        rises  = 0;
        aborts = 0;
        pb     = busy;
        for (int i = 0; i < 110; i++) begin
            if (!pb && busy) rises++;
            if (pb && !busy) begin
                aborts++;
                check("bounce_abort_idx", int'(active_idx), 2);
            end
            pb = busy;
            btn_raw[1] = (i < 100) && (((i / 5) % 2) == 0);
            @(negedge clk);
        end
        check("bounce_busy_rises", rises, 10);
        check("bounce_aborts", aborts, 10);
        check("bounce_level", int'(btn_level), 0);

        // Simultaneous presses on buttons 0 and 3 with the pointer at 3
        do_reset(1'b0, r);
        @(negedge clk);
        p = cyc;
        btn_raw = 4'b1001;
        push(p + 19, 4'b1000, 4'b1000);
        push(p + 36, 4'b1001, 4'b0001);
        wait_until(p + 3);
        check("t3_busy_b3", int'(busy), 1);
        check("t3_idx_b3", int'(active_idx), 3);
        wait_until(p + 20);
        check("t3_busy_b0", int'(busy), 1);
        check("t3_idx_b0", int'(active_idx), 0);
        wait_until(p + 40);
        btn_raw = '0;
        do_reset(1'b1, r);

        // Reset on the 10th qualify cycle of button 1, then full requalification
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        p = cyc;
        btn_raw = 4'b0010;
        wait_until(p + 12);
        check("t4_busy_pre", int'(busy), 1);
        check("t4_idx_pre", int'(active_idx), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t4_rst_busy", int'(busy), 0);
        check("t4_rst_idx", int'(active_idx), 0);
        check("t4_rst_level", int'(btn_level), 0);
        check("t4_rst_pulse", int'(btn_pulse), 0);
        rst = 1'b0;
        push(p + 35, 4'b0010, 4'b0010);
        wait_until(p + 34);
        check("t4_level_early", int'(btn_level), 0);
        wait_until(p + 40);
        btn_raw = '0;
        do_reset(1'b1, r);

        repeat (5) @(negedge clk);
        check("events_pending", exp_q.size(), 0);
        while (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            $display("FAIL missing_event cyc=%0d level=%b pulse=%b", mon_e.cyc, mon_e.level, mon_e.pulse);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
